// File: rtl/pr_hrav_pr_sequencer_pkg.sv
// Shared definitions for the PR sequencer: FSM state encodings and PR result codes.
// The dispatcher debug path imports the same package to decode state and status.
package pr_hrav_pr_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DRAIN    = 3'd1,
        ST_DECOUPLE = 3'd2,
        ST_RECONF   = 3'd3,
        ST_SETTLE   = 3'd4,
        ST_RECOUPLE = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    localparam logic [1:0] PR_STAT_OK       = 2'b00;
    localparam logic [1:0] PR_STAT_DRAIN_TO = 2'b01;
    localparam logic [1:0] PR_STAT_ICAP_ERR = 2'b10;
    localparam logic [1:0] PR_STAT_ICAP_TO  = 2'b11;

endpackage

// File: rtl/pr_hrav_pr_sequencer_down_counter.sv
// Loadable down-counter shared by the drain timeout, ICAP timeout and settle delay.
// It saturates at zero so a timeout condition stays asserted until the next load.
module pr_hrav_down_counter #(
    parameter int C_CNT_W = 24
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    input  logic               load,
    input  logic [C_CNT_W-1:0] load_val,
    input  logic               dec,
    output logic [C_CNT_W-1:0] value,
    output logic               zero
);

    localparam logic [C_CNT_W-1:0] ONE = C_CNT_W'(1);

    // Load has priority over decrement; decrement holds at zero.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (dec && (value != '0)) begin
            value <= value - ONE;
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/pr_hrav_pr_sequencer.sv
// Partial-reconfiguration sequencer for a two-core scanner: drains the target core,
// de-couples it from the dispatcher, holds its RP reset through ICAP load and settle,
// then re-couples it. The other core keeps running untouched.
// pr_req/icap_done/icap_err are single-cycle pulses with no back-pressure: a pr_req
// seen outside IDLE is dropped and answered with a pr_reject pulse one cycle later.
module pr_hrav_pr_sequencer
    import pr_hrav_pr_sequencer_pkg::*;
#(
    parameter int C_CNT_W         = 24,
    parameter int C_DRAIN_TIMEOUT = 1024,
    parameter int C_ICAP_TIMEOUT  = 16777215,
    parameter int C_SETTLE_CYCLES = 16
) (
    input  logic       ACLK,
    input  logic       ARESETN,
    input  logic       pr_req,
    input  logic       pr_core,
    input  logic       core0_idle,
    input  logic       core1_idle,
    input  logic       icap_done,
    input  logic       icap_err,
    output logic       core_0_enb,
    output logic       core_1_enb,
    output logic       core0_rp_rstn,
    output logic       core1_rp_rstn,
    output logic       pr_busy,
    output logic       pr_done,
    output logic       pr_reject,
    output logic [1:0] pr_status,
    output state_t     dbg_state
);

    localparam logic [C_CNT_W-1:0] DRAIN_LOAD  = C_CNT_W'(C_DRAIN_TIMEOUT);
    localparam logic [C_CNT_W-1:0] ICAP_LOAD   = C_CNT_W'(C_ICAP_TIMEOUT);
    localparam logic [C_CNT_W-1:0] SETTLE_LOAD = C_CNT_W'(C_SETTLE_CYCLES - 1);

    state_t             state, state_n;
    logic               tgt, tgt_n;
    logic [1:0]         fail, fail_n;
    logic [1:0]         status, status_n;
    logic [1:0]         enb, enb_n;
    logic [1:0]         rstn, rstn_n;
    logic [1:0]         core_idle;
    logic               cnt_load, cnt_dec, cnt_zero;
    logic [C_CNT_W-1:0] cnt_val, cnt_value;

    assign core_idle = {core1_idle, core0_idle};

    pr_hrav_down_counter #(.C_CNT_W(C_CNT_W)) u_cnt (
        .ACLK     (ACLK),
        .ARESETN  (ARESETN),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .value    (cnt_value),
        .zero     (cnt_zero)
    );

    // FSM state register.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) state <= ST_IDLE;
        else          state <= state_n;
    end

    // Next-state, counter control and next values of target/fail/status/enable/reset regs.
    always_comb begin
        state_n  = state;
        tgt_n    = tgt;
        fail_n   = fail;
        status_n = status;
        enb_n    = enb;
        rstn_n   = rstn;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pr_req) begin
                    tgt_n    = pr_core;
                    cnt_load = 1'b1;
                    cnt_val  = DRAIN_LOAD;
                    // A core left off by a failed PR carries no traffic; skip the drain.
                    state_n  = fail[pr_core] ? ST_DECOUPLE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (core_idle[tgt]) begin
                    state_n = ST_DECOUPLE;
                end else if (cnt_zero) begin
                    status_n = PR_STAT_DRAIN_TO;
                    state_n  = ST_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_DECOUPLE: begin
                enb_n[tgt]  = 1'b0;
                rstn_n[tgt] = 1'b0;
                cnt_load    = 1'b1;
                cnt_val     = ICAP_LOAD;
                state_n     = ST_RECONF;
            end
            ST_RECONF: begin
                if (icap_err) begin
                    status_n    = PR_STAT_ICAP_ERR;
                    fail_n[tgt] = 1'b1;
                    state_n     = ST_DONE;
                end else if (icap_done) begin
                    cnt_load = 1'b1;
                    cnt_val  = SETTLE_LOAD;
                    state_n  = ST_SETTLE;
                end else if (cnt_zero) begin
                    status_n    = PR_STAT_ICAP_TO;
                    fail_n[tgt] = 1'b1;
                    state_n     = ST_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt_zero) begin
                    rstn_n[tgt] = 1'b1;
                    state_n     = ST_RECOUPLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_RECOUPLE: begin
                enb_n[tgt]  = 1'b1;
                fail_n[tgt] = 1'b0;
                status_n    = PR_STAT_OK;
                state_n     = ST_DONE;
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Registered outputs and bookkeeping; busy/done follow the state being entered.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            tgt       <= 1'b0;
            fail      <= 2'b00;
            status    <= PR_STAT_OK;
            enb       <= 2'b11;
            rstn      <= 2'b11;
            pr_busy   <= 1'b0;
            pr_done   <= 1'b0;
            pr_reject <= 1'b0;
        end else begin
            tgt       <= tgt_n;
            fail      <= fail_n;
            status    <= status_n;
            enb       <= enb_n;
            rstn      <= rstn_n;
            pr_busy   <= (state_n != ST_IDLE);
            pr_done   <= (state_n == ST_DONE);
            pr_reject <= pr_req && (state != ST_IDLE);
        end
    end

    assign core_0_enb    = enb[0];
    assign core_1_enb    = enb[1];
    assign core0_rp_rstn = rstn[0];
    assign core1_rp_rstn = rstn[1];
    assign pr_status     = status;
    assign dbg_state     = state;

endmodule
